// File: rtl/spi_fpga_slave_sync_if.sv
// Bus bundle for spi_fpga_slave_sync: transmit handshake, SPI pins, receive/status
// outputs and a debug view of the FSM state.
interface spi_fpga_slave_sync_if #(
    parameter int PACK_LENGTH = 8
);
    // Transmit handshake: a word moves into the holding register on any clock edge
    // where IN_TRANSMIT_VALID and OUT_TRANSMIT_READY are both high; READY means "empty".
    logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA;
    logic                   IN_TRANSMIT_VALID;
    logic                   OUT_TRANSMIT_READY;
    logic                   IN_CS;
    logic                   IN_SCLK;
    logic                   IN_MOSI;
    logic                   OUT_MISO;
    logic                   OUT_MISO_ENABLE;
    logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA;
    logic                   OUT_RECEIVE_VALID;
    logic                   OUT_UNDERRUN;
    logic                   OUT_ABORT;
    logic                   OUT_BUSY;
    logic [1:0]             dbg_state;

    modport slave (
        input  IN_TRANSMIT_DATA, IN_TRANSMIT_VALID, IN_CS, IN_SCLK, IN_MOSI,
        output OUT_TRANSMIT_READY, OUT_MISO, OUT_MISO_ENABLE, OUT_RECEIVE_DATA,
        output OUT_RECEIVE_VALID, OUT_UNDERRUN, OUT_ABORT, OUT_BUSY, dbg_state
    );

    modport master (
        output IN_TRANSMIT_DATA, IN_TRANSMIT_VALID, IN_CS, IN_SCLK, IN_MOSI,
        input  OUT_TRANSMIT_READY, OUT_MISO, OUT_MISO_ENABLE, OUT_RECEIVE_DATA,
        input  OUT_RECEIVE_VALID, OUT_UNDERRUN, OUT_ABORT, OUT_BUSY, dbg_state
    );
endinterface

// File: rtl/spi_fpga_slave_sync.sv
// SPI slave clocked by the system clock: CS/SCLK/MOSI are synchronised and edge-detected,
// MISO words come from a one-word holding register fed through a valid/ready handshake.
module spi_fpga_slave_sync #(
    parameter bit CPOL                       = 1'b1,
    parameter bit CPHA                       = 1'b1,
    parameter int PACK_LENGTH                = 8,
    parameter bit PACK_BIT_SEQUENCE_TRANSMIT = 1'b1,
    parameter bit PACK_BIT_SEQUENCE_RECEIVE  = 1'b1,
    parameter int SYNC_STAGES                = 2
) (
    input logic                  IN_CLOCK,
    input logic                  IN_RESET_N,
    spi_fpga_slave_sync_if.slave bus
);

    localparam int CNT_W = $clog2(PACK_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PACK_LENGTH - 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

    logic [1:0]             state, state_n;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [PACK_LENGTH-1:0] rx_shift, rx_shift_n;
    logic [PACK_LENGTH-1:0] tx_shift, tx_shift_n;
    logic [PACK_LENGTH-1:0] hold_data, hold_data_n;
    logic                   hold_full, hold_full_n;
    logic                   word_seen, word_seen_n;
    logic [PACK_LENGTH-1:0] rx_data, rx_data_n;
    logic                   rx_valid, rx_valid_n;
    logic                   underrun, underrun_n;
    logic                   abort_p, abort_n;
    logic                   miso_q, miso_n;
    logic                   load;

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;
    assign lead_edge   = (sclk_s != sclk_d) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        word_seen_n = word_seen;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        underrun_n  = 1'b0;
        abort_n     = 1'b0;
        load        = 1'b0;

        case (state)
            ST_WAIT_IDLE: begin
                // A reset taken with CS low must not be mistaken for a new frame.
                if (cs_s) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n     = ST_ACTIVE;
                    bit_cnt_n   = '0;
                    rx_shift_n  = '0;
                    word_seen_n = 1'b0;
                    load        = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_n    = ST_IDLE;
                    abort_n    = (bit_cnt != '0);
                    bit_cnt_n  = '0;
                    rx_shift_n = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_n = PACK_BIT_SEQUENCE_RECEIVE ?
                                     {rx_shift[PACK_LENGTH-2:0], mosi_s} :
                                     {mosi_s, rx_shift[PACK_LENGTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_n   = rx_shift_n;
                            rx_valid_n  = 1'b1;
                            bit_cnt_n   = '0;
                            word_seen_n = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                    // With CPHA=1 the frame's first leading edge leaves the preloaded bit alone.
                    if (shift_edge) begin
                        if (bit_cnt == '0) begin
                            load = !CPHA || word_seen;
                        end else begin
                            tx_shift_n = PACK_BIT_SEQUENCE_TRANSMIT ?
                                         {tx_shift[PACK_LENGTH-2:0], 1'b0} :
                                         {1'b0, tx_shift[PACK_LENGTH-1:1]};
                        end
                    end
                end
            end
            default: state_n = ST_WAIT_IDLE;
        endcase

        if (load) begin
            if (hold_full) begin
                tx_shift_n  = hold_data;
                hold_full_n = 1'b0;
            end else begin
                tx_shift_n = '0;
                underrun_n = 1'b1;
            end
        end

        // Accepted only into an empty holding register, so it never feeds a same-cycle load.
        if (bus.IN_TRANSMIT_VALID && !hold_full) begin
            hold_data_n = bus.IN_TRANSMIT_DATA;
            hold_full_n = 1'b1;
        end

        miso_n = (state_n == ST_ACTIVE) &&
                 (PACK_BIT_SEQUENCE_TRANSMIT ? tx_shift_n[PACK_LENGTH-1] : tx_shift_n[0]);
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            cs_sync   <= '0;
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= CPOL;
            state     <= ST_WAIT_IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            word_seen <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            abort_p   <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.IN_CS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.IN_SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.IN_MOSI};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_shift  <= rx_shift_n;
            tx_shift  <= tx_shift_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            word_seen <= word_seen_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            underrun  <= underrun_n;
            abort_p   <= abort_n;
            miso_q    <= miso_n;
        end
    end

    assign bus.OUT_TRANSMIT_READY = ~hold_full;
    assign bus.OUT_MISO           = miso_q;
    assign bus.OUT_MISO_ENABLE    = (state == ST_ACTIVE);
    assign bus.OUT_BUSY           = (state == ST_ACTIVE);
    assign bus.OUT_RECEIVE_DATA   = rx_data;
    assign bus.OUT_RECEIVE_VALID  = rx_valid;
    assign bus.OUT_UNDERRUN       = underrun;
    assign bus.OUT_ABORT          = abort_p;
    assign bus.dbg_state          = state;

endmodule

// File: tb/tb_spi_fpga_slave_sync.sv
// Directed bench for spi_fpga_slave_sync: five slave instances (four SPI modes plus an
// LSB-first build) driven by a cycle-timed SPI master model at 16 clocks per bit.
module tb_spi_fpga_slave_sync;
  localparam int N = 5;
  localparam int H = 8;
  localparam bit CPOL_A [N] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit CPHA_A [N] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit MSB_A  [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic       cs [N];
  logic       sclk [N];
  logic       mosi;
  logic [7:0] tx_data [N];
  logic       tx_valid [N];
  logic       miso [N], miso_en [N], ready [N], rx_valid [N], under [N], abort_p [N], busy [N];
  logic [7:0] rx_data [N];
  logic [1:0] dbg [N];

  int         vcnt [N] = '{default: 0};
  int         ucnt [N] = '{default: 0};
  int         acnt [N] = '{default: 0};
  logic [7:0] last_rx [N] = '{default: 8'h00};
  int         n_vec = 0;
  int         n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_fpga_slave_sync_if #(.PACK_LENGTH(8)) bus ();
    assign bus.IN_TRANSMIT_DATA  = tx_data[g];
    assign bus.IN_TRANSMIT_VALID = tx_valid[g];
    assign bus.IN_CS             = cs[g];
    assign bus.IN_SCLK           = sclk[g];
    assign bus.IN_MOSI           = mosi;
    assign ready[g]              = bus.OUT_TRANSMIT_READY;
    assign miso[g]               = bus.OUT_MISO;
    assign miso_en[g]            = bus.OUT_MISO_ENABLE;
    assign rx_data[g]            = bus.OUT_RECEIVE_DATA;
    assign rx_valid[g]           = bus.OUT_RECEIVE_VALID;
    assign under[g]              = bus.OUT_UNDERRUN;
    assign abort_p[g]            = bus.OUT_ABORT;
    assign busy[g]               = bus.OUT_BUSY;
    assign dbg[g]                = bus.dbg_state;

    spi_fpga_slave_sync #(
      .CPOL(CPOL_A[g]), .CPHA(CPHA_A[g]), .PACK_LENGTH(8),
      .PACK_BIT_SEQUENCE_TRANSMIT(MSB_A[g]), .PACK_BIT_SEQUENCE_RECEIVE(MSB_A[g]),
      .SYNC_STAGES(2)
    ) dut (
      .IN_CLOCK(clk),
      .IN_RESET_N(rst_n),
      .bus(bus)
    );
  end

  // Pulse monitor: counts one-cycle pulses and captures each received word.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rx_valid[i]) begin
        vcnt[i]++;
        last_rx[i] = rx_data[i];
      end
      if (under[i]) ucnt[i]++;
      if (abort_p[i]) acnt[i]++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall(input int idx);
    cs[idx] = 1'b0;
    wait_cyc(H);
  endtask

  task automatic cs_rise(input int idx);
    wait_cyc(H);
    cs[idx] = 1'b1;
    wait_cyc(2 * H);
  endtask

  // Master side of one word (or the first nbits of it) in the instance's mode and bit order.
  task automatic xfer(input int idx, input logic [7:0] w, input int nbits, output logic [7:0] r);
    int b;
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = MSB_A[idx] ? 7 - i : i;
      if (!CPHA_A[idx]) begin
        mosi = w[b];
        wait_cyc(H);
        r[b] = miso[idx];
        sclk[idx] = ~CPOL_A[idx];
        wait_cyc(H);
        sclk[idx] = CPOL_A[idx];
      end else begin
        sclk[idx] = ~CPOL_A[idx];
        mosi = w[b];
        wait_cyc(H);
        r[b] = miso[idx];
        sclk[idx] = CPOL_A[idx];
        wait_cyc(H);
      end
    end
  endtask

  task automatic tx_load(input int idx, input logic [7:0] d);
    int t;
    t = 0;
    while (!ready[idx] && t < 200) begin
      wait_cyc(1);
      t++;
    end
    n_vec++;
    if (!ready[idx]) begin
      n_err++;
      $display("FAIL tx_ready_wait inst=%0d ready=%b required=1 after %0d cycles", idx, ready[idx], t);
    end else begin
      tx_data[idx]  = d;
      tx_valid[idx] = 1'b1;
      wait_cyc(1);
      tx_valid[idx] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({miso[i], miso_en[i], ready[i], rx_valid[i], under[i], abort_p[i], busy[i], rx_data[i], dbg[i]}
          !== {7'b0010000, 8'h00, 2'd0}) begin
        n_err++;
        $display("FAIL reset_outputs inst=%0d got miso=%b en=%b rdy=%b vld=%b und=%b abt=%b busy=%b data=%h st=%0d required rdy=1 rest 0",
                 i, miso[i], miso_en[i], ready[i], rx_valid[i], under[i], abort_p[i], busy[i], rx_data[i], dbg[i]);
      end
    end
    rst_n = 1'b1;
    wait_cyc(10);
    n_vec++;
    if (dbg[0] !== 2'd1) begin
      n_err++;
      $display("FAIL idle_after_reset got state=%0d required 1", dbg[0]);
    end
  endtask

  task automatic test_modes();
    logic [7:0] got;
    int v0, u0;
    for (int idx = 0; idx < 4; idx++) begin
      tx_load(idx, 8'h53);
      n_vec++;
      if (ready[idx] !== 1'b0) begin
        n_err++;
        $display("FAIL ready_drop inst=%0d got %b required 0", idx, ready[idx]);
      end
      v0 = vcnt[idx];
      u0 = ucnt[idx];
      cs_fall(idx);
      n_vec++;
      if ({busy[idx], miso_en[idx], ready[idx]} !== 3'b111) begin
        n_err++;
        $display("FAIL frame_start inst=%0d busy/en/rdy got %b required 111", idx, {busy[idx], miso_en[idx], ready[idx]});
      end
      // CPHA=0 reloads on the final trailing edge, so give it a follow-on word to avoid an underrun.
      if (!CPHA_A[idx]) tx_load(idx, 8'h00);
      xfer(idx, 8'hEA, 8, got);
      cs_rise(idx);
      n_vec++;
      if (got !== 8'h53) begin
        n_err++;
        $display("FAIL mode_miso inst=%0d got %h required 53", idx, got);
      end
      n_vec++;
      if (vcnt[idx] - v0 !== 1 || last_rx[idx] !== 8'hEA) begin
        n_err++;
        $display("FAIL mode_rx inst=%0d pulses=%0d data=%h required 1 pulse data ea", idx, vcnt[idx] - v0, last_rx[idx]);
      end
      n_vec++;
      if (ucnt[idx] - u0 !== 0 || {busy[idx], miso_en[idx], miso[idx]} !== 3'b000) begin
        n_err++;
        $display("FAIL mode_end inst=%0d underruns=%0d busy/en/miso=%b required 0 and 000",
                 idx, ucnt[idx] - u0, {busy[idx], miso_en[idx], miso[idx]});
      end
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] got;
    int v0;
    v0 = vcnt[4];
    tx_load(4, 8'h80);
    cs_fall(4);
    xfer(4, 8'h01, 8, got);
    cs_rise(4);
    n_vec++;
    if (got !== 8'h80) begin
      n_err++;
      $display("FAIL lsb_miso got %h required 80", got);
    end
    n_vec++;
    if (vcnt[4] - v0 !== 1 || last_rx[4] !== 8'h01) begin
      n_err++;
      $display("FAIL lsb_rx pulses=%0d data=%h required 1 pulse data 01", vcnt[4] - v0, last_rx[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    int v0, u0;
    tx_load(0, 8'h53);
    v0 = vcnt[0];
    u0 = ucnt[0];
    cs_fall(0);
    tx_load(0, 8'hA5);
    xfer(0, 8'hEA, 8, r0);
    xfer(0, 8'h3C, 8, r1);
    cs_rise(0);
    n_vec++;
    if (r0 !== 8'h53 || r1 !== 8'hA5) begin
      n_err++;
      $display("FAIL b2b_miso got %h %h required 53 a5", r0, r1);
    end
    n_vec++;
    if (vcnt[0] - v0 !== 2 || last_rx[0] !== 8'h3C || ucnt[0] - u0 !== 0) begin
      n_err++;
      $display("FAIL b2b_rx pulses=%0d last=%h underruns=%0d required 2 3c 0", vcnt[0] - v0, last_rx[0], ucnt[0] - u0);
    end
    n_vec++;
    if (ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready got %b required 1", ready[0]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    int u0, v0;
    u0 = ucnt[0];
    v0 = vcnt[0];
    cs_fall(0);
    n_vec++;
    if (ucnt[0] - u0 !== 1) begin
      n_err++;
      $display("FAIL underrun_pulse got %0d pulses required 1", ucnt[0] - u0);
    end
    xfer(0, 8'h5A, 8, got);
    cs_rise(0);
    n_vec++;
    if (got !== 8'h00 || vcnt[0] - v0 !== 1 || last_rx[0] !== 8'h5A || ucnt[0] - u0 !== 1) begin
      n_err++;
      $display("FAIL underrun_word miso=%h pulses=%0d rx=%h underruns=%0d required 00 1 5a 1",
               got, vcnt[0] - v0, last_rx[0], ucnt[0] - u0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int a0, v0;
    a0 = acnt[0];
    v0 = vcnt[0];
    cs_fall(0);
    xfer(0, 8'hEA, 3, got);
    cs_rise(0);
    n_vec++;
    if (acnt[0] - a0 !== 1 || vcnt[0] - v0 !== 0 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse aborts=%0d valids=%0d busy=%b required 1 0 0", acnt[0] - a0, vcnt[0] - v0, busy[0]);
    end
    tx_load(0, 8'h53);
    cs_fall(0);
    xfer(0, 8'hEA, 8, got);
    cs_rise(0);
    n_vec++;
    if (got !== 8'h53 || vcnt[0] - v0 !== 1 || last_rx[0] !== 8'hEA || acnt[0] - a0 !== 1) begin
      n_err++;
      $display("FAIL abort_recover miso=%h valids=%0d rx=%h aborts=%0d required 53 1 ea 1",
               got, vcnt[0] - v0, last_rx[0], acnt[0] - a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    int v0;
    tx_load(0, 8'h53);
    cs_fall(0);
    xfer(0, 8'hEA, 3, got);
    n_vec++;
    if (busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_frame_busy got %b required 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({miso[0], miso_en[0], ready[0], rx_valid[0], under[0], abort_p[0], busy[0], rx_data[0]} !== {7'b0010000, 8'h00}) begin
      n_err++;
      $display("FAIL async_reset miso/en/rdy/vld/und/abt/busy=%b data=%h required 0010000 00",
               {miso[0], miso_en[0], ready[0], rx_valid[0], under[0], abort_p[0], busy[0]}, rx_data[0]);
    end
    wait_cyc(3);
    sclk[0] = CPOL_A[0];
    rst_n = 1'b1;
    wait_cyc(20);
    v0 = vcnt[0];
    xfer(0, 8'hFF, 2, got);
    n_vec++;
    if (dbg[0] !== 2'd0 || busy[0] !== 1'b0 || vcnt[0] !== v0) begin
      n_err++;
      $display("FAIL wait_idle_hold state=%0d busy=%b valids=%0d required state 0 busy 0 valids 0", dbg[0], busy[0], vcnt[0] - v0);
    end
    cs[0] = 1'b1;
    wait_cyc(2 * H);
    n_vec++;
    if (dbg[0] !== 2'd1) begin
      n_err++;
      $display("FAIL idle_after_cs_high got state=%0d required 1", dbg[0]);
    end
    tx_load(0, 8'h53);
    cs_fall(0);
    xfer(0, 8'hEA, 8, got);
    cs_rise(0);
    n_vec++;
    if (got !== 8'h53 || vcnt[0] - v0 !== 1 || last_rx[0] !== 8'hEA) begin
      n_err++;
      $display("FAIL post_reset_frame miso=%h valids=%0d rx=%h required 53 1 ea", got, vcnt[0] - v0, last_rx[0]);
    end
  endtask

  initial begin
    mosi = 1'b0;
    for (int i = 0; i < N; i++) begin
      cs[i]       = 1'b1;
      sclk[i]     = CPOL_A[i];
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end
    wait_cyc(5);
    test_reset();
    test_modes();
    test_bit_order();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_fpga_slave_sync.md
Name: spi_fpga_slave_sync

Overview:
System-clock-domain SPI slave. It is the responder to SPI_FPGA_MASTER and is driven by IN_CLOCK rather than by SCLK. CS, SCLK and MOSI are synchronised and edge-detected, received words go to a valid pulse, and transmit words are accepted through a one-word holding register with a valid/ready handshake. It supports back-to-back words under one CS assertion and flags aborted frames and transmit underruns.

Parameters:
CPOL, 1'b1, SCLK idle level.
CPHA, 1'b1, 0: sample on leading edge, shift on trailing edge. 1: shift on leading edge, sample on trailing edge.
PACK_LENGTH, 8, bits per word (2..32).
PACK_BIT_SEQUENCE_TRANSMIT, 1, 1: MSB first, 0: LSB first, applies to MISO.
PACK_BIT_SEQUENCE_RECEIVE, 1, 1: first received bit is MSB, 0: first received bit is LSB.
SYNC_STAGES, 2, flop stages on IN_CS, IN_SCLK and IN_MOSI (>=2).

Ports:
IN_CLOCK  in  1  system clock
IN_RESET_N  in  1  asynchronous, active-low reset
IN_TRANSMIT_DATA  in  PACK_LENGTH  word to send on MISO
IN_TRANSMIT_VALID  in  1  transmit word offered
OUT_TRANSMIT_READY  out  1  holding register empty
IN_CS  in  1  chip select, active low
IN_SCLK  in  1  SPI clock
IN_MOSI  in  1  master-out data
OUT_MISO  out  1  slave-out data
OUT_MISO_ENABLE  out  1  tri-state enable, high while selected
OUT_RECEIVE_DATA  out  PACK_LENGTH  last complete received word
OUT_RECEIVE_VALID  out  1  one-cycle pulse when OUT_RECEIVE_DATA updates
OUT_UNDERRUN  out  1  one-cycle pulse: word loaded while holding register empty
OUT_ABORT  out  1  one-cycle pulse: CS released mid-word
OUT_BUSY  out  1  high in ACTIVE state

Behaviour:
- Reset (async assert, sync release): state WAIT_IDLE, counters and shifters 0, holding register empty.
- Reset values: OUT_TRANSMIT_READY=1; all other outputs 0.
- Timing constraint: each SCLK phase must last >= SYNC_STAGES+2 IN_CLOCK periods. Behaviour outside this constraint is undefined.
- Edge detection works on synchronised signals.
  - Leading edge: SCLK transition away from CPOL.
  - Trailing edge: SCLK transition back to CPOL.
  - Sample edge is leading when CPHA=0, trailing when CPHA=1. Shift edge is the other one.
- FSM:
  - WAIT_IDLE: moves to IDLE when synchronised CS is high. This covers reset with CS low.
  - IDLE: on synchronised CS falling, load the tx shifter, clear bit_cnt, go to ACTIVE.
  - ACTIVE: on synchronised CS rising, go to IDLE. If bit_cnt != 0, pulse OUT_ABORT and discard the partial word.
- Tx load rule (at CS fall and at each word boundary):
  - If the holding register is full: shifter <= holding, holding becomes empty.
  - If it is empty: shifter <= 0, pulse OUT_UNDERRUN.
  - A handshake in the same cycle as a load is not used for that load; the new word stays in holding for the next word.
- Handshake: a word is transferred when IN_TRANSMIT_VALID & OUT_TRANSMIT_READY on a clock edge. OUT_TRANSMIT_READY drops the next cycle and returns high the cycle after the holding register is loaded into the shifter.
- MISO:
  - OUT_MISO = shifter MSB when PACK_BIT_SEQUENCE_TRANSMIT=1, shifter LSB when 0. Registered output.
  - OUT_MISO and OUT_MISO_ENABLE are 0 outside ACTIVE.
  - Shift edge action by CPHA:
    - CPHA=0: the first bit is valid 1 cycle after the CS-fall detect. Each trailing edge shifts; the trailing edge that ends a word reloads instead.
    - CPHA=1: the first leading edge of a frame does not shift. Leading edges 2..PACK_LENGTH of a word shift. A leading edge with bit_cnt==0 after a completed word reloads.
- Receive:
  - Each sample edge shifts synchronised MOSI into the rx shifter in the order set by PACK_BIT_SEQUENCE_RECEIVE, and increments bit_cnt.
  - When bit_cnt reaches PACK_LENGTH: OUT_RECEIVE_DATA <= word, OUT_RECEIVE_VALID pulses for 1 cycle, bit_cnt wraps to 0.
  - Latency: VALID is asserted SYNC_STAGES+1 cycles after the raw last sample edge.
  - There is no back-pressure; the consumer must take data on the pulse. OUT_RECEIVE_DATA holds until the next word.
- Ignored events:
  - SCLK edges outside ACTIVE.
  - A CS rise and an SCLK edge detected in the same cycle: the CS rise wins and the edge is ignored.
- Reset mid-frame: outputs clear immediately. No new frame starts until CS has been seen high.

Test Plan:
- Master at 50 MHz with BIT_PER_SECOND=3125000, CPOL=1, CPHA=1. Master sends 8'hEA; slave is preloaded with 8'h53. -> OUT_RECEIVE_DATA=8'hEA with one VALID pulse; master receives 8'h53; OUT_UNDERRUN=0.
- Same word pair repeated for each CPOL/CPHA combination (0/0, 0/1, 1/0). -> identical results in all modes.
- Both bit-sequence parameters =0 on both ends, data 8'h01/8'h80. -> bytes received unchanged; first MOSI bit on the wire is 1.
- Two words under one CS, with slave holding 8'h53 then 8'hA5 supplied after READY rises. -> two VALID pulses; master sees 8'h53 then 8'hA5.
- Frame started with the holding register empty. -> OUT_UNDERRUN pulses at CS fall; MISO stays 0 for the whole word.
- Force CS high after 3 SCLK cycles. -> OUT_ABORT pulses and VALID does not. The next full frame receives correctly.
- Assert IN_RESET_N low mid-frame with CS held low. -> all outputs 0 within the same cycle. Slave stays in WAIT_IDLE until CS goes high, then the next frame is correct.
